// File: rtl/axi_protocol_checker.sv
// axi_protocol_checker: passive AXI3/AXI4 link monitor reporting registered error flags, codes, counters and outstanding counts
module axi_protocol_checker #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ID_WIDTH        = 4,
  parameter int LEN_WIDTH       = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [LEN_WIDTH-1:0]    awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic [1:0]              awlock,
  input  logic [3:0]              awcache,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  input  logic                    awready,
  input  logic [ID_WIDTH-1:0]     wid,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [LEN_WIDTH-1:0]    arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic [1:0]              arlock,
  input  logic [3:0]              arcache,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  input  logic                    rready,
  input  logic                    clear_errors,
  output logic                    err_valid,
  output logic [3:0]              err_code,
  output logic [11:0]             err_sticky,
  output logic [15:0]             err_count,
  output logic [CW-1:0]           wr_outstanding,
  output logic [CW-1:0]           rd_outstanding
);
  localparam int AXW = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + 14;
  localparam int WW = ID_WIDTH + DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int BW = ID_WIDTH + 2;
  localparam int RW = ID_WIDTH + DATA_WIDTH + 3;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int TW = TIMEOUT_CYCLES < 2 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = TIMEOUT_CYCLES != 0;
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_OUTSTANDING);
  logic [AXW-1:0] w_aw_pl, r_aw_pl, w_ar_pl, r_ar_pl;
  logic [WW-1:0] w_w_pl, r_w_pl;
  logic [BW-1:0] w_b_pl, r_b_pl;
  logic [RW-1:0] w_r_pl, r_r_pl;
  logic [4:0] w_v, w_r, r_v, r_r, w_st, w_hs, w_chg, w_to;
  logic [TW-1:0] r_to [5];
  logic [LEN_WIDTH-1:0] r_fifo [MAX_OUTSTANDING];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_fc, r_comp;
  logic [LEN_WIDTH-1:0] r_beat, w_head;
  logic w_empty, w_has_head, w_push, w_pop;
  logic [11:0] w_fail;
  logic [3:0] w_code;
  function automatic logic [CW-1:0] upd(input logic [CW-1:0] c, input logic inc, input logic dec);
    return (inc && dec) ? c : (inc && c != MAXC) ? c + 1'b1 : (dec && c != '0) ? c - 1'b1 : c;
  endfunction
  assign w_aw_pl = {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot};
  assign w_ar_pl = {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot};
  assign w_w_pl = {wid, wdata, wstrb, wlast};
  assign w_b_pl = {bid, bresp};
  assign w_r_pl = {rid, rdata, rresp, rlast};
  assign w_v = {rvalid, arvalid, bvalid, wvalid, awvalid};
  assign w_r = {rready, arready, bready, wready, awready};
  assign w_hs = w_v & w_r;
  // A channel is "stalled" when the previous edge saw valid without ready
  assign w_st = r_v & ~r_r;
  assign w_chg = {w_r_pl != r_r_pl, w_ar_pl != r_ar_pl, w_b_pl != r_b_pl, w_w_pl != r_w_pl, w_aw_pl != r_aw_pl};
  assign w_empty = r_fc == '0;
  // Same-cycle AW handshake on an empty FIFO bypasses awlen straight to the head
  assign w_has_head = !w_empty || w_hs[0];
  assign w_head = w_empty ? awlen : r_fifo[r_rp];
  assign w_push = w_hs[0] && r_fc != MAXC;
  assign w_pop = w_hs[1] && wlast && w_has_head;
  genvar g;
  for (g = 0; g < 5; g++) begin : g_to
    assign w_to[g] = TO_EN && w_v[g] && !w_r[g] && r_to[g] == TO_LAST;
    always_ff @(posedge aclk)
      if (areset) r_to[g] <= '0;
      else r_to[g] <= (w_v[g] && !w_r[g]) ? (r_to[g] == TO_MAX ? r_to[g] : r_to[g] + 1'b1) : '0;
  end
  always_comb begin
    w_fail = '0;
    w_fail[0] = w_st[0] && w_v[0] && w_chg[0];
    w_fail[1] = w_st[0] && !w_v[0];
    w_fail[2] = w_st[1] && w_v[1] && w_chg[1];
    w_fail[3] = w_st[1] && !w_v[1];
    w_fail[4] = w_st[2] && (!w_v[2] || w_chg[2]);
    w_fail[5] = w_st[3] && (!w_v[3] || w_chg[3]);
    w_fail[6] = w_st[4] && (!w_v[4] || w_chg[4]);
    w_fail[7] = w_hs[1] && w_has_head && (wlast != (r_beat == w_head));
    w_fail[8] = w_hs[1] && !w_has_head;
    w_fail[9] = (w_hs[2] && r_comp == '0) || (w_hs[4] && rd_outstanding == '0);
    w_fail[10] = (w_hs[0] && wr_outstanding == MAXC) || (w_hs[3] && rd_outstanding == MAXC);
    w_fail[11] = |w_to;
    w_code = '0;
    for (int i = 11; i >= 0; i--) w_code = w_fail[i] ? 4'(i) : w_code;
  end
  always_ff @(posedge aclk)
    if (w_push) r_fifo[r_wp] <= awlen;
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_aw_pl <= '0;
      r_ar_pl <= '0;
      r_w_pl <= '0;
      r_b_pl <= '0;
      r_r_pl <= '0;
      r_v <= '0;
      r_r <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_fc <= '0;
      r_comp <= '0;
      r_beat <= '0;
      wr_outstanding <= '0;
      rd_outstanding <= '0;
      err_valid <= 1'b0;
      err_code <= '0;
      err_sticky <= '0;
      err_count <= '0;
    end else begin
      r_aw_pl <= w_aw_pl;
      r_ar_pl <= w_ar_pl;
      r_w_pl <= w_w_pl;
      r_b_pl <= w_b_pl;
      r_r_pl <= w_r_pl;
      r_v <= w_v;
      r_r <= w_r;
      r_wp <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp <= w_pop ? r_rp + 1'b1 : r_rp;
      r_fc <= upd(r_fc, w_push, w_pop);
      r_comp <= upd(r_comp, w_hs[1] && wlast, w_hs[2]);
      r_beat <= w_hs[1] ? (wlast ? '0 : r_beat + 1'b1) : r_beat;
      wr_outstanding <= upd(wr_outstanding, w_hs[0], w_hs[2]);
      rd_outstanding <= upd(rd_outstanding, w_hs[3], w_hs[4] && rlast);
      err_valid <= |w_fail;
      err_code <= w_code;
      err_sticky <= (clear_errors ? '0 : err_sticky) | w_fail;
      err_count <= |w_fail ? (clear_errors ? 16'd1 : (err_count == '1 ? err_count : err_count + 1'b1))
                           : (clear_errors ? '0 : err_count);
    end
  end
endmodule

// File: tb/tb_axi_protocol_checker.sv
// tb_axi_protocol_checker: directed scoreboard bench for axi_protocol_checker
module tb_axi_protocol_checker;
  logic aclk = 0, areset = 1, clear_errors = 0;
  logic [3:0] awid = 0, wid = 0, bid = 0, arid = 0, rid = 0;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata = 0;
  logic [3:0] awlen = 0, arlen = 0, awcache = 0, arcache = 0, wstrb = 0;
  logic [2:0] awsize = 0, arsize = 0, awprot = 0, arprot = 0;
  logic [1:0] awburst = 0, arburst = 0, awlock = 0, arlock = 0, bresp = 0, rresp = 0;
  logic awvalid = 0, awready = 0, wlast = 0, wvalid = 0, wready = 0, bvalid = 0, bready = 0;
  logic arvalid = 0, arready = 0, rlast = 0, rvalid = 0, rready = 0;
  logic err_valid, z_valid;
  logic [3:0] err_code, z_code, wr_outstanding, rd_outstanding, z_wo, z_ro;
  logic [11:0] err_sticky, z_sticky;
  logic [15:0] err_count, z_count;
  int checks = 0, errors = 0;
  typedef struct {
    string tag;
    logic ev;
    logic [3:0] ec;
    logic [11:0] es;
    logic [15:0] cnt;
    logic [3:0] wo;
    logic [3:0] ro;
  } exp_t;
  exp_t q[$];
  always #5 aclk = ~aclk;
  axi_protocol_checker dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .clear_errors(clear_errors), .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
    .err_count(err_count), .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );
  axi_protocol_checker #(.TIMEOUT_CYCLES(0)) dut_z (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .clear_errors(clear_errors), .err_valid(z_valid), .err_code(z_code), .err_sticky(z_sticky),
    .err_count(z_count), .wr_outstanding(z_wo), .rd_outstanding(z_ro)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask
  task automatic step(input string tag, input logic ev, input logic [3:0] ec, input logic [11:0] es,
                      input logic [15:0] cnt, input logic [3:0] wo, input logic [3:0] ro);
    exp_t e;
    e.tag = tag; e.ev = ev; e.ec = ec; e.es = es; e.cnt = cnt; e.wo = wo; e.ro = ro;
    q.push_back(e);
    @(posedge aclk);
    #1;
    e = q.pop_front();
    chk({e.tag, ".err_valid"}, 32'(err_valid), 32'(e.ev));
    if (e.ev) chk({e.tag, ".err_code"}, 32'(err_code), 32'(e.ec));
    chk({e.tag, ".err_sticky"}, 32'(err_sticky), 32'(e.es));
    chk({e.tag, ".err_count"}, 32'(err_count), 32'(e.cnt));
    chk({e.tag, ".wr_outstanding"}, 32'(wr_outstanding), 32'(e.wo));
    chk({e.tag, ".rd_outstanding"}, 32'(rd_outstanding), 32'(e.ro));
  endtask
  task automatic idle();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0; bvalid = 0; bready = 0;
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; rlast = 0; clear_errors = 0;
  endtask
  task automatic do_reset(input string tag);
    areset = 1;
    step(tag, 0, 0, 0, 0, 0, 0);
    areset = 0;
    idle();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    idle();
    do_reset("reset");
    awvalid = 1; awaddr = 32'h100;
    step("aw_stall", 0, 0, 0, 0, 0, 0);
    awaddr = 32'h104;
    step("aw_addr_chg", 1, 0, 12'h001, 1, 0, 0);
    awready = 1;
    step("aw_accept", 0, 0, 12'h001, 1, 1, 0);
    do_reset("reset_b");
    awvalid = 1; awready = 1; awlen = 3;
    step("aw_len3_a", 0, 0, 0, 0, 1, 0);
    awvalid = 0; awready = 0; wvalid = 1; wready = 1;
    for (int k = 0; k < 2; k++) begin
      wdata = 32'hA0 + k;
      step("w_beat_a", 0, 0, 0, 0, 1, 0);
    end
    wdata = 32'hA2; wlast = 1;
    step("wlast_early", 1, 7, 12'h080, 1, 1, 0);
    wvalid = 0; wlast = 0; bvalid = 1; bready = 1;
    step("b_a", 0, 0, 12'h080, 1, 0, 0);
    bvalid = 0; awvalid = 1; awready = 1;
    step("aw_len3_b", 0, 0, 12'h080, 1, 1, 0);
    awvalid = 0; awready = 0; wvalid = 1; wready = 1;
    for (int k = 0; k < 4; k++) begin
      wdata = 32'hB0 + k; wlast = (k == 3);
      step("w_beat_b", 0, 0, 12'h080, 1, 1, 0);
    end
    wvalid = 0; wlast = 0;
    step("wait_b", 0, 0, 12'h080, 1, 1, 0);
    bvalid = 1; bready = 1;
    step("b_b", 0, 0, 12'h080, 1, 0, 0);
    do_reset("reset_c");
    awvalid = 1; awready = 1; awlen = 0;
    for (int k = 1; k <= 8; k++) begin
      awaddr = 32'h1000 + 32'(k);
      step("aw_fill", 0, 0, 0, 0, 4'(k), 0);
    end
    step("aw_overflow", 1, 10, 12'h400, 1, 8, 0);
    awvalid = 0; awready = 0; bvalid = 1; bready = 1;
    step("b_orphan", 1, 9, 12'h600, 2, 7, 0);
    bvalid = 0;
    step("after_orphan", 0, 0, 12'h600, 2, 7, 0);
    do_reset("reset_d");
    arvalid = 1; araddr = 32'h200;
    for (int k = 1; k <= 16; k++)
      step("ar_timeout", k == 16, 11, k == 16 ? 12'h800 : 12'h0, k == 16 ? 16'd1 : 16'd0, 0, 0);
    step("ar_timeout_once", 0, 0, 12'h800, 1, 0, 0);
    chk("timeout_disabled.err_sticky", 32'(z_sticky), 32'h0);
    arready = 1;
    step("ar_accept", 0, 0, 12'h800, 1, 0, 1);
    arvalid = 0; arready = 0; rvalid = 1; rready = 1; rlast = 1;
    step("r_last", 0, 0, 12'h800, 1, 0, 0);
    do_reset("reset_e");
    wvalid = 1; bvalid = 1;
    step("w_b_stall", 0, 0, 0, 0, 0, 0);
    wvalid = 0; bvalid = 0;
    step("w_b_drop", 1, 3, 12'h018, 1, 0, 0);
    awvalid = 1;
    step("aw_stall2", 0, 0, 12'h018, 1, 0, 0);
    awvalid = 0; clear_errors = 1;
    step("clear_with_new", 1, 1, 12'h002, 1, 0, 0);
    clear_errors = 0;
    step("after_clear", 0, 0, 12'h002, 1, 0, 0);
    clear_errors = 1;
    step("clear_only", 0, 0, 0, 0, 0, 0);
    clear_errors = 0; rvalid = 1; rready = 1; rlast = 1;
    step("r_orphan", 1, 9, 12'h200, 1, 0, 0);
    rvalid = 0; rready = 0; rlast = 0; awvalid = 1; awready = 1; awlen = 1;
    step("aw_mid", 0, 0, 12'h200, 1, 1, 0);
    awvalid = 0; awready = 0; wvalid = 1; wready = 1;
    step("w_mid", 0, 0, 12'h200, 1, 1, 0);
    wready = 0;
    do_reset("reset_mid_burst");
    awvalid = 1; awready = 1; awlen = 1;
    step("fresh_aw", 0, 0, 0, 0, 1, 0);
    awvalid = 0; awready = 0; wvalid = 1; wready = 1;
    step("fresh_w0", 0, 0, 0, 0, 1, 0);
    wlast = 1;
    step("fresh_w1", 0, 0, 0, 0, 1, 0);
    wvalid = 0; wlast = 0; bvalid = 1; bready = 1;
    step("fresh_b", 0, 0, 0, 0, 0, 0);
    bvalid = 0; bready = 0;
    step("fresh_idle", 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
